// File: rtl/rom_fetch_ctrl_pkg.sv
// Shared constants for the instruction-ROM fetch controller: widths, reset PC
// and the encoding of the per-cycle ROM port grant.
package rom_fetch_ctrl_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  localparam logic [ADDR_W-1:0] RESET_PC = 12'h000;

  localparam logic [1:0] G_IDLE  = 2'd0;
  localparam logic [1:0] G_FETCH = 2'd1;
  localparam logic [1:0] G_DATA  = 2'd2;

endpackage

// File: rtl/rom_fetch_ctrl_fifo.sv
// Prefetch buffer of {pc, instr} entries; flush empties it synchronously and
// wins over a push or pop in the same cycle.
module fetch_fifo #(
  parameter int W     = 44,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full buffer is only taken when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Single ROM read port shared between the sequential instruction prefetcher and
// code-space data loads; data alternates with fetch so it never starves it.
module rom_fetch_ctrl
  import rom_fetch_ctrl_pkg::*;
#(
  parameter int                        P_ADDR_W   = rom_fetch_ctrl_pkg::ADDR_W,
  parameter int                        P_DATA_W   = rom_fetch_ctrl_pkg::DATA_W,
  parameter int                        P_DEPTH    = rom_fetch_ctrl_pkg::DEPTH,
  parameter logic [P_ADDR_W-1:0]       P_RESET_PC = rom_fetch_ctrl_pkg::RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  output logic [P_ADDR_W-1:0] rom_addr,
  input  logic [P_DATA_W-1:0] rom_data,
  input  logic                halt,
  input  logic                redirect_valid,
  input  logic [P_ADDR_W-1:0] redirect_pc,
  output logic                inst_valid,
  output logic [P_DATA_W-1:0] inst_data,
  output logic [P_ADDR_W-1:0] inst_pc,
  input  logic                inst_ready,
  input  logic                dreq_valid,
  input  logic [P_ADDR_W-1:0] dreq_addr,
  output logic                dreq_ready,
  output logic                drsp_valid,
  output logic [P_DATA_W-1:0] drsp_data
);

  localparam logic [P_ADDR_W-1:0] WORD_MASK = ~P_ADDR_W'(3);

  logic [P_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic                last_was_data_q;
  logic                drsp_valid_q;
  logic [P_DATA_W-1:0] drsp_data_q;
  logic [1:0]          grant;
  logic                pop, fetch_ok, push, fifo_full, fifo_empty;
  logic [P_ADDR_W+P_DATA_W-1:0] fifo_dout;

  always_comb begin
    pop      = inst_valid & inst_ready;
    fetch_ok = ~halt & ~redirect_valid & (~fifo_full | pop);
    grant    = G_IDLE;
    if (dreq_valid && (!last_was_data_q || !fetch_ok)) grant = G_DATA;
    else if (fetch_ok)                                 grant = G_FETCH;

    case (grant)
      G_DATA:  rom_addr = dreq_addr & WORD_MASK;
      G_FETCH: rom_addr = fetch_pc_q & WORD_MASK;
      default: rom_addr = fetch_pc_q;
    endcase
    dreq_ready = (grant == G_DATA);
    push       = (grant == G_FETCH);

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = redirect_pc & WORD_MASK;
    else if (push)      fetch_pc_d = fetch_pc_q + P_ADDR_W'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q      <= P_RESET_PC & WORD_MASK;
      last_was_data_q <= 1'b0;
      drsp_valid_q    <= 1'b0;
      drsp_data_q     <= '0;
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      last_was_data_q <= dreq_ready;
      drsp_valid_q    <= dreq_ready;
      if (dreq_ready) drsp_data_q <= rom_data;
    end
  end

  fetch_fifo #(
    .W     (P_ADDR_W + P_DATA_W),
    .DEPTH (P_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({fetch_pc_q, rom_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign inst_valid = ~fifo_empty;
  assign {inst_pc, inst_data} = fifo_dout;
  assign drsp_valid = drsp_valid_q;
  assign drsp_data  = drsp_data_q;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Bench for rom_fetch_ctrl: directed vector table, hand-written corner sequences
// and a randomized run, all checked against a queue-based reference model.
module tb_rom_fetch_ctrl;

  logic        clk, rst;
  logic [11:0] rom_addr;
  logic [31:0] rom_data;
  logic        halt, redirect_valid;
  logic [11:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [11:0] inst_pc;
  logic        inst_ready;
  logic        dreq_valid;
  logic [11:0] dreq_addr;
  logic        dreq_ready, drsp_valid;
  logic [31:0] drsp_data;

  logic [31:0] rom [1024];
  assign rom_data = rom[rom_addr[11:2]];

  rom_fetch_ctrl dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_ready(dreq_ready), .drsp_valid(drsp_valid), .drsp_data(drsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the prefetch buffer is a plain queue of {pc, word}.
  typedef struct { logic [11:0] pc; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic [11:0] m_fpc;
  bit          m_lwd, m_dv, chk_en;
  logic [31:0] m_dd;

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic model_step();
    bit e_iv, pop, fok, dg, fg;
    logic [11:0] e_ra;
    ent_t e;
    e_iv = (mq.size() != 0);
    pop  = e_iv && inst_ready;
    fok  = !halt && !redirect_valid && ((mq.size() < 4) || pop);
    dg   = dreq_valid && (!m_lwd || !fok);
    fg   = !dg && fok;
    e_ra = dg ? (dreq_addr & 12'hFFC) : m_fpc;
    if (chk_en) begin
      chk("m_inst_valid", 32'(inst_valid), 32'(e_iv));
      if (e_iv) begin
        chk("m_inst_pc", 32'(inst_pc), 32'(mq[0].pc));
        chk("m_inst_data", inst_data, mq[0].d);
      end
      chk("m_rom_addr", 32'(rom_addr), 32'(e_ra));
      chk("m_dreq_ready", 32'(dreq_ready), 32'(dg));
      chk("m_drsp_valid", 32'(drsp_valid), 32'(m_dv));
      chk("m_drsp_data", drsp_data, m_dd);
    end
    if (rst) begin
      mq.delete(); m_fpc = 12'h000; m_lwd = 0; m_dv = 0; m_dd = 32'h0;
    end else begin
      m_dv  = dg;
      if (dg) m_dd = rom[dreq_addr[11:2]];
      m_lwd = dg;
      if (redirect_valid) begin
        mq.delete();
        m_fpc = redirect_pc & 12'hFFC;
      end else begin
        if (pop) void'(mq.pop_front());
        if (fg) begin
          e.pc = m_fpc; e.d = rom[m_fpc[11:2]];
          mq.push_back(e);
          m_fpc = m_fpc + 12'd4;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit rst; bit rdy; bit dv;
    bit iv; logic [11:0] ipc; logic [11:0] raddr; bit dr; bit drv;
  } vec_t;
  vec_t tab[26];

  function automatic vec_t mk(bit r, bit rd, bit dv, bit iv, logic [11:0] ipc,
                              logic [11:0] ra, bit dr, bit drv);
    vec_t v;
    v.rst = r; v.rdy = rd; v.dv = dv; v.iv = iv; v.ipc = ipc;
    v.raddr = ra; v.dr = dr; v.drv = drv;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] wexp [4];
    bit found;

    // Streaming from reset, then a reset with the CPU stalled, release, and alternation.
    tab[0]  = mk(1,1,0, 0,12'h000,12'h000, 0,0);
    tab[1]  = mk(0,1,0, 0,12'h000,12'h000, 0,0);
    tab[2]  = mk(0,1,0, 1,12'h000,12'h004, 0,0);
    tab[3]  = mk(0,1,0, 1,12'h004,12'h008, 0,0);
    tab[4]  = mk(0,1,0, 1,12'h008,12'h00C, 0,0);
    tab[5]  = mk(1,0,0, 1,12'h00C,12'h010, 0,0);
    tab[6]  = mk(0,0,0, 0,12'h000,12'h000, 0,0);
    tab[7]  = mk(0,0,0, 1,12'h000,12'h004, 0,0);
    tab[8]  = mk(0,0,0, 1,12'h000,12'h008, 0,0);
    tab[9]  = mk(0,0,0, 1,12'h000,12'h00C, 0,0);
    for (int k = 10; k < 16; k++) tab[k] = mk(0,0,0, 1,12'h000,12'h010, 0,0);
    tab[16] = mk(0,1,0, 1,12'h000,12'h010, 0,0);
    tab[17] = mk(0,1,0, 1,12'h004,12'h014, 0,0);
    tab[18] = mk(0,1,0, 1,12'h008,12'h018, 0,0);
    tab[19] = mk(0,1,0, 1,12'h00C,12'h01C, 0,0);
    tab[20] = mk(0,1,0, 1,12'h010,12'h020, 0,0);
    tab[21] = mk(0,1,1, 1,12'h014,12'h200, 1,0);
    tab[22] = mk(0,1,1, 1,12'h018,12'h024, 0,1);
    tab[23] = mk(0,1,1, 1,12'h01C,12'h200, 1,0);
    tab[24] = mk(0,1,1, 1,12'h020,12'h028, 0,1);
    tab[25] = mk(0,1,0, 1,12'h024,12'h02C, 0,0);

    for (int i = 0; i < 1024; i++) rom[i] = 32'(i) * 32'h11;
    rst = 1; halt = 0; redirect_valid = 0; redirect_pc = 12'h000;
    inst_ready = 1; dreq_valid = 0; dreq_addr = 12'h200;
    chk_en = 0;
    settle(); model_step();
    chk_en = 1;

    for (int k = 0; k < 26; k++) begin
      rst = tab[k].rst; inst_ready = tab[k].rdy; dreq_valid = tab[k].dv;
      dreq_addr = 12'h200;
      settle();
      chk("tab_inst_valid", 32'(inst_valid), 32'(tab[k].iv));
      if (tab[k].iv) begin
        chk("tab_inst_pc", 32'(inst_pc), 32'(tab[k].ipc));
        chk("tab_inst_data", inst_data, {22'd0, tab[k].ipc[11:2]} * 32'h11);
      end
      chk("tab_rom_addr", 32'(rom_addr), 32'(tab[k].raddr));
      chk("tab_dreq_ready", 32'(dreq_ready), 32'(tab[k].dr));
      chk("tab_drsp_valid", 32'(drsp_valid), 32'(tab[k].drv));
      if (tab[k].drv) chk("tab_drsp_data", drsp_data, 32'h880);
      model_step();
    end
    rst = 0; dreq_valid = 0;

    // Redirect to an unaligned target while the buffer is full.
    inst_ready = 0;
    for (int k = 0; k < 4; k++) begin settle(); model_step(); end
    redirect_valid = 1; redirect_pc = 12'h103;
    settle(); model_step();
    redirect_valid = 0;
    settle();
    chk("redir_flush_valid", 32'(inst_valid), 32'd0);
    model_step();
    inst_ready = 1;
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      settle();
      if (inst_valid) begin
        chk("redir_first_pc", 32'(inst_pc), 32'h100);
        found = 1;
      end
      model_step();
    end
    chk("redir_wait", 32'(found), 32'd1);

    // Fetch address wrap at the top of the ROM.
    redirect_valid = 1; redirect_pc = 12'hFF8;
    settle(); model_step();
    redirect_valid = 0;
    settle();
    chk("wrap_gap_valid", 32'(inst_valid), 32'd0);
    model_step();
    wexp[0] = 12'hFF8; wexp[1] = 12'hFFC; wexp[2] = 12'h000; wexp[3] = 12'h004;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("wrap_valid", 32'(inst_valid), 32'd1);
      chk("wrap_pc", 32'(inst_pc), 32'(wexp[k]));
      model_step();
    end

    // Halt with a continuous data stream, then reset mid-stream.
    halt = 1; dreq_valid = 1;
    for (int k = 0; k < 6; k++) begin
      dreq_addr = 12'($urandom);
      settle();
      chk("halt_dreq_ready", 32'(dreq_ready), 32'd1);
      chk("halt_rom_addr", 32'(rom_addr), 32'(dreq_addr & 12'hFFC));
      model_step();
    end
    rst = 1;
    settle(); model_step();
    rst = 0;
    settle();
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_drsp_valid", 32'(drsp_valid), 32'd0);
    chk("rst_drsp_data", drsp_data, 32'd0);
    model_step();
    halt = 0; dreq_valid = 0;

    // Randomized run with random ROM contents.
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 99) == 0);
      halt           = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 12'($urandom);
      inst_ready     = ($urandom_range(0, 3) != 0);
      dreq_valid     = ($urandom_range(0, 1) == 1);
      dreq_addr      = 12'($urandom);
      settle(); model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
